frv_eic: RTL and testbench
==========================

# frv_eic

External interrupt controller for the FRV core. It collects up to 15 asynchronous external interrupt lines and synchronises them. Each line can be configured as edge-triggered or level-sensitive and individually masked. The block presents the highest-priority eligible source to `frv_interrupt` as `ex_pending`/`ex_cause`. Firmware claims a source and signals completion through a small register port, with one source in service at a time and no nesting.

## Interface

- `NSRC`, default 15: number of sources, legal range 1..15. Source id `i` (1..NSRC) is driven by `irq_in[i-1]`.
- `SYNC_STAGES`, default 2: synchroniser depth, minimum 2.

- `g_clk`, in, 1: clock. All logic is rising-edge.
- `g_resetn`, in, 1: reset. Synchronous, active-low.
- `irq_in`, in, NSRC: raw asynchronous interrupt lines.
- `reg_en`, in, 1: register access request, one cycle per access.
- `reg_wen`, in, 1: 1 = write, 0 = read. Only meaningful while `reg_en` is high.
- `reg_addr`, in, 2: register select.
  - 0 = ENABLE
  - 1 = EDGE
  - 2 = PENDING
  - 3 = CLAIM
- `reg_wdata`, in, 32: write data.
- `reg_rdata`, out, 32: read data, registered.
- `ex_pending`, out, 1: an eligible source exists. Connects to `frv_interrupt.ex_pending`.
- `ex_cause`, out, 4: id of the highest-priority eligible source, 0 when none. Connects to `frv_interrupt.ex_cause`.

## Operation

**Bit layout.** In ENABLE, EDGE and PENDING, bit `i` corresponds to source id `i`. Bit 0 and bits above NSRC read 0 and ignore writes.

**Synchroniser.** Each `irq_in` bit passes through SYNC_STAGES flops to give `sync[i]`. A further flop holds `prev[i]` for edge detection.

**Pending.**
- Edge-mode source: sticky bit `lat[i]`, set when `sync[i] & ~prev[i]`.
- Level-mode source: pending is `sync[i]`, with no storage.

**Eligibility and priority.**
- `elig = pending & ENABLE & ~in_service_mask`. Only one source can be in service.
- While `in_service != 0`, `elig` is forced to 0.
- Priority: the lowest id wins.
- `ex_pending` and `ex_cause` are registered from `elig`.

**Register writes.**
- ENABLE: plain write.
- EDGE: plain write. Any source whose EDGE bit changes has `lat[i]` cleared.
- PENDING: write-1-to-clear of `lat[i]`. Bits for level-mode sources are ignored.
- CLAIM: completion. If `in_service != 0` and `reg_wdata[3:0] == in_service`, then `in_service <= 0`. Any other value is ignored with no state change.

**Register reads.**
- ENABLE, EDGE: current value.
- PENDING: current pending vector.
- CLAIM: returns `{28'b0, id}`.
  - `id` is the current highest-priority eligible source; 0 if none, or if a source is already in service.
  - If `id != 0`: `in_service <= id`, and `lat[id]` is cleared when that source is edge mode.

**Collisions.** A new rising edge in the same cycle as a claim clear or a W1C of the same bit wins: `lat` stays 1.

**Level sources.** A level source still asserted at completion becomes eligible again. This is intended; firmware must quiesce the device before completing.

**Reset values.** All of the following are 0:
- `reg_rdata`, `ex_pending`, `ex_cause`
- ENABLE, EDGE, `lat`
- synchroniser flops and `prev`
- `in_service`

Reset asserted mid-claim discards the in-service state.

## Timing

- **Input latency.** An `irq_in` rise before the clock edge ending cycle 0 gives:
  - `sync` high in cycle SYNC_STAGES;
  - `lat`/eligibility resolved in the same cycle;
  - `ex_pending`/`ex_cause` valid in cycle SYNC_STAGES+1.
  - Default total latency: 3 cycles.
- **Read latency.** `reg_rdata` is valid in the cycle after `reg_en`. It holds its value until the next read; writes do not change it.
- **Claim to deassert.** A claim in cycle T:
  - `in_service` updates at the end of T;
  - `reg_rdata` is valid in T+1;
  - `ex_pending` drops in T+2.
- **Complete to re-raise.** A completing write in cycle T allows `ex_pending` to re-raise no earlier than T+2.
- **Mask update.** An ENABLE write takes effect on `ex_pending` two cycles later. Masking a source that is currently presented drops `ex_pending` at T+2.
- **No back-pressure.** Every access completes in one cycle.

## Test plan

- **Reset.** Assert `g_resetn=0` for 2 cycles with all `irq_in` high -> all outputs 0 and all registers read 0.
- **Edge latch and claim.** ENABLE=0x0008, EDGE=0x0008; pulse `irq_in[2]` for 1 cycle -> `ex_pending=1`, `ex_cause=3` at cycle 3. CLAIM read returns 3 and `ex_pending=0` two cycles later. PENDING bit 3 reads 0. Write CLAIM=3 -> `in_service` cleared.
- **Priority and masking.** Level sources 2 and 5 both high with ENABLE=0x0024 -> `ex_cause=2`. Write ENABLE=0x0020 -> `ex_cause=5` two cycles later.
- **Single in-service.** Claim id 5, then raise source 1 -> `ex_pending` stays 0 and a CLAIM read returns 0. Write CLAIM=4 -> ignored. Write CLAIM=5 -> `ex_pending=1`, `ex_cause=1`.
- **Edge collision.** Edge source 4 claimed, with a new rising edge of `irq_in[3]` in the same cycle as the claim -> `lat[4]` remains 1. After completing 4, `ex_cause=4` again.
- **Reset mid-claim.** Claim id 7, assert reset for 1 cycle with level `irq_in[6]` held high -> `in_service=0` and ENABLE=0, so `ex_pending=0` until ENABLE bit 7 is rewritten. It then rises 2 cycles after the write.

Source files
------------

// File: rtl/frv_eic.sv
// frv_eic: external interrupt controller for the FRV core.
// Synchronises up to 15 interrupt lines and latches edge-mode sources.
// Presents the lowest-id eligible source on ex_pending/ex_cause.
// Firmware claims one source at a time through a 4-register port.
module frv_eic #(
  parameter int unsigned NSRC        = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic [NSRC-1:0] irq_in,
  input  logic            reg_en,
  input  logic            reg_wen,
  input  logic [1:0]      reg_addr,
  input  logic [31:0]     reg_wdata,
  output logic [31:0]     reg_rdata,
  output logic            ex_pending,
  output logic [3:0]      ex_cause
);

  // Internal vectors are indexed by source id; bit 0 is never a source.
  localparam int unsigned VW = 16;
  localparam logic [VW-1:0] ID_MASK = VW'((32'd1 << (NSRC + 1)) - 32'd2);

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_EDGE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_CLAIM   = 2'd3;

  logic [VW-1:0] sync_q [SYNC_STAGES];
  logic [VW-1:0] sync_d [SYNC_STAGES];
  logic [VW-1:0] prev_q, prev_d;
  logic [VW-1:0] lat_q, lat_d;
  logic [VW-1:0] enable_q, enable_d;
  logic [VW-1:0] edge_q, edge_d;
  logic [3:0]    in_service_q, in_service_d;
  logic [31:0]   reg_rdata_q, reg_rdata_d;
  logic          ex_pending_q, ex_pending_d;
  logic [3:0]    ex_cause_q, ex_cause_d;

  logic [VW-1:0] irq_id_c;
  logic [VW-1:0] sync_c;
  logic [VW-1:0] rise_c;
  logic [VW-1:0] pending_c;
  logic [VW-1:0] elig_c;
  logic [3:0]    id_c;
  logic [VW-1:0] lat_clr_c;
  logic [VW-1:0] edge_chg_c;
  logic          rd_c;
  logic          wr_c;
  logic          unused_wdata_c;

  assign irq_id_c       = VW'({irq_in, 1'b0});
  assign sync_c         = sync_q[SYNC_STAGES-1];
  assign rd_c           = reg_en & ~reg_wen;
  assign wr_c           = reg_en & reg_wen;
  assign unused_wdata_c = ^reg_wdata[31:VW];

  // Pending vector: edge sources see this cycle's rise immediately, level sources follow sync.
  always_comb begin
    rise_c    = sync_c & ~prev_q & ID_MASK;
    pending_c = (((lat_q | rise_c) & edge_q) | (sync_c & ~edge_q)) & ID_MASK;
    elig_c    = (in_service_q != 4'd0) ? '0 : (pending_c & enable_q);
  end

  // Priority encoder: lowest eligible id wins.
  always_comb begin
    id_c = 4'd0;
    for (int i = VW - 1; i >= 1; i--) begin
      if (elig_c[i]) id_c = 4'(i);
    end
  end

  // Next-state for synchroniser, registers, claim state and outputs.
  always_comb begin
    sync_d[0] = irq_id_c;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    prev_d       = sync_c;
    enable_d     = enable_q;
    edge_d       = edge_q;
    in_service_d = in_service_q;
    reg_rdata_d  = reg_rdata_q;
    lat_clr_c    = '0;
    edge_chg_c   = '0;

    if (wr_c) begin
      case (reg_addr)
        ADDR_ENABLE:  enable_d = reg_wdata[VW-1:0] & ID_MASK;
        ADDR_EDGE: begin
          edge_d     = reg_wdata[VW-1:0] & ID_MASK;
          edge_chg_c = edge_q ^ edge_d;
        end
        ADDR_PENDING: lat_clr_c = reg_wdata[VW-1:0] & edge_q;
        default: begin
          if ((in_service_q != 4'd0) && (reg_wdata[3:0] == in_service_q))
            in_service_d = 4'd0;
        end
      endcase
    end

    if (rd_c) begin
      case (reg_addr)
        ADDR_ENABLE:  reg_rdata_d = 32'(enable_q);
        ADDR_EDGE:    reg_rdata_d = 32'(edge_q);
        ADDR_PENDING: reg_rdata_d = 32'(pending_c);
        default: begin
          reg_rdata_d = 32'(id_c);
          if (id_c != 4'd0) begin
            in_service_d = id_c;
            lat_clr_c    = (VW'(1) << id_c) & edge_q;
          end
        end
      endcase
    end

    // A fresh rise beats a claim/W1C clear; a mode change always clears.
    lat_d = (((lat_q & ~lat_clr_c) | (rise_c & edge_q)) & ~edge_chg_c) & ID_MASK;

    ex_pending_d = |elig_c;
    ex_cause_d   = id_c;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q       <= '0;
      lat_q        <= '0;
      enable_q     <= '0;
      edge_q       <= '0;
      in_service_q <= 4'd0;
      reg_rdata_q  <= 32'd0;
      ex_pending_q <= 1'b0;
      ex_cause_q   <= 4'd0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      prev_q       <= prev_d;
      lat_q        <= lat_d;
      enable_q     <= enable_d;
      edge_q       <= edge_d;
      in_service_q <= in_service_d;
      reg_rdata_q  <= reg_rdata_d;
      ex_pending_q <= ex_pending_d;
      ex_cause_q   <= ex_cause_d;
    end
  end

  assign reg_rdata  = reg_rdata_q;
  assign ex_pending = ex_pending_q;
  assign ex_cause   = ex_cause_q;

endmodule

// File: tb/tb_frv_eic.sv
// Directed testbench for frv_eic with hand-computed expectations.
module tb_frv_eic;

  localparam int unsigned NSRC = 15;

  logic            g_clk = 1'b0;
  logic            g_resetn;
  logic [NSRC-1:0] irq_in;
  logic            reg_en;
  logic            reg_wen;
  logic [1:0]      reg_addr;
  logic [31:0]     reg_wdata;
  logic [31:0]     reg_rdata;
  logic            ex_pending;
  logic [3:0]      ex_cause;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] d;

  frv_eic #(.NSRC(NSRC), .SYNC_STAGES(2)) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .irq_in     (irq_in),
    .reg_en     (reg_en),
    .reg_wen    (reg_wen),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .ex_pending (ex_pending),
    .ex_cause   (ex_cause)
  );

  always #5 g_clk = ~g_clk;

  // Advance n cycles; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge g_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] v);
    reg_en = 1'b1; reg_wen = 1'b1; reg_addr = a; reg_wdata = v;
    tick(1);
    reg_en = 1'b0; reg_wen = 1'b0; reg_wdata = 32'd0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] v);
    reg_en = 1'b1; reg_wen = 1'b0; reg_addr = a;
    tick(1);
    v = reg_rdata;
    reg_en = 1'b0;
  endtask

  initial begin
    // Reset with every line high.
    g_resetn = 1'b0; irq_in = '1;
    reg_en = 1'b0; reg_wen = 1'b0; reg_addr = 2'd0; reg_wdata = 32'd0;
    tick(2);
    chk("rst_pending", 32'(ex_pending), 32'd0);
    chk("rst_cause",   32'(ex_cause),   32'd0);
    chk("rst_rdata",   reg_rdata,       32'd0);
    irq_in = '0; g_resetn = 1'b1;
    tick(1);
    reg_read(2'd0, d); chk("rst_enable",  d, 32'd0);
    reg_read(2'd1, d); chk("rst_edge",    d, 32'd0);
    reg_read(2'd2, d); chk("rst_pendreg", d, 32'd0);
    reg_read(2'd3, d); chk("rst_claim",   d, 32'd0);

    // Edge latch on id 3 with a one-cycle pulse.
    reg_write(2'd0, 32'h8);
    reg_write(2'd1, 32'h8);
    irq_in[2] = 1'b1; tick(1);
    irq_in[2] = 1'b0; tick(1);
    chk("edge_c2_pending", 32'(ex_pending), 32'd0);
    tick(1);
    chk("edge_c3_pending", 32'(ex_pending), 32'd1);
    chk("edge_c3_cause",   32'(ex_cause),   32'd3);
    reg_read(2'd3, d); chk("edge_claim", d, 32'd3);
    chk("edge_claim_t1_pending", 32'(ex_pending), 32'd1);
    tick(1);
    chk("edge_claim_t2_pending", 32'(ex_pending), 32'd0);
    chk("edge_claim_t2_cause",   32'(ex_cause),   32'd0);
    reg_read(2'd2, d); chk("edge_pend_cleared", d, 32'd0);
    reg_write(2'd3, 32'd3);
    // Re-pulse proves the completion released in-service.
    irq_in[2] = 1'b1; tick(1);
    irq_in[2] = 1'b0; tick(2);
    chk("edge_repulse_pending", 32'(ex_pending), 32'd1);
    chk("edge_repulse_cause",   32'(ex_cause),   32'd3);
    reg_read(2'd2, d); chk("edge_pend_set", d, 32'h8);
    reg_write(2'd2, 32'h8);
    chk("rdata_hold_on_write", reg_rdata, 32'h8);
    chk("w1c_t1_pending", 32'(ex_pending), 32'd1);
    tick(1);
    chk("w1c_t2_pending", 32'(ex_pending), 32'd0);
    reg_write(2'd0, 32'd0);
    reg_write(2'd1, 32'd0);

    // Level sources 2 and 5: priority then masking.
    irq_in[1] = 1'b1; irq_in[4] = 1'b1;
    reg_write(2'd0, 32'h24);
    tick(3);
    chk("prio_pending", 32'(ex_pending), 32'd1);
    chk("prio_cause",   32'(ex_cause),   32'd2);
    reg_write(2'd0, 32'h20);
    chk("mask_t1_cause", 32'(ex_cause), 32'd2);
    tick(1);
    chk("mask_t2_cause",   32'(ex_cause),   32'd5);
    chk("mask_t2_pending", 32'(ex_pending), 32'd1);

    // Single in-service: claim 5, then source 1 must wait.
    reg_write(2'd0, 32'h22);
    reg_read(2'd3, d); chk("svc_claim5", d, 32'd5);
    irq_in[0] = 1'b1;
    tick(4);
    chk("svc_blocked_pending", 32'(ex_pending), 32'd0);
    reg_read(2'd3, d); chk("svc_claim_busy", d, 32'd0);
    reg_write(2'd3, 32'd4);
    tick(2);
    chk("svc_wrong_complete", 32'(ex_pending), 32'd0);
    reg_write(2'd3, 32'd5);
    chk("svc_complete_t1", 32'(ex_pending), 32'd0);
    tick(1);
    chk("svc_complete_t2_pending", 32'(ex_pending), 32'd1);
    chk("svc_complete_t2_cause",   32'(ex_cause),   32'd1);
    reg_read(2'd3, d); chk("svc_claim1", d, 32'd1);
    irq_in = '0;
    reg_write(2'd3, 32'd1);
    reg_write(2'd0, 32'd0);
    tick(4);
    chk("svc_quiet", 32'(ex_pending), 32'd0);

    // Edge collision: new rise on id 4 in the claim cycle keeps lat set.
    reg_write(2'd1, 32'h10);
    reg_write(2'd0, 32'h10);
    irq_in[3] = 1'b1; tick(1);
    irq_in[3] = 1'b0; tick(2);
    chk("coll_cause", 32'(ex_cause), 32'd4);
    irq_in[3] = 1'b1; tick(2);
    reg_read(2'd3, d); chk("coll_claim", d, 32'd4);
    irq_in[3] = 1'b0;
    reg_read(2'd2, d); chk("coll_lat_kept", d, 32'h10);
    chk("coll_in_service_pending", 32'(ex_pending), 32'd0);
    reg_write(2'd3, 32'd4);
    tick(1);
    chk("coll_reraise_pending", 32'(ex_pending), 32'd1);
    chk("coll_reraise_cause",   32'(ex_cause),   32'd4);
    reg_write(2'd2, 32'h10);
    reg_write(2'd1, 32'd0);
    reg_write(2'd0, 32'd0);
    tick(2);

    // Reset in the middle of a claim on level id 7.
    irq_in[6] = 1'b1;
    reg_write(2'd0, 32'h80);
    tick(3);
    chk("rstmid_cause", 32'(ex_cause), 32'd7);
    reg_read(2'd3, d); chk("rstmid_claim", d, 32'd7);
    g_resetn = 1'b0; tick(1);
    g_resetn = 1'b1; tick(3);
    chk("rstmid_pending", 32'(ex_pending), 32'd0);
    reg_read(2'd0, d); chk("rstmid_enable", d, 32'd0);
    reg_write(2'd0, 32'h80);
    chk("rstmid_en_t1", 32'(ex_pending), 32'd0);
    tick(1);
    chk("rstmid_en_t2_pending", 32'(ex_pending), 32'd1);
    chk("rstmid_en_t2_cause",   32'(ex_cause),   32'd7);
    reg_read(2'd3, d); chk("rstmid_reclaim", d, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
